// File: rtl/hack_pkg.sv
// Shared types and instruction-field positions for the Hack CPU control unit.
// The TRAP state is only reachable when HACK_CPU_TRAP_EN is defined.
package hack_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        READ,
        EXEC,
        WRITE,
        TRAP
    } state_e;

    localparam int IR_TYPE    = 15;
    localparam int IR_A       = 12;
    localparam int IR_COMP_HI = 11;
    localparam int IR_COMP_LO = 6;
    localparam int IR_DEST_HI = 5;
    localparam int IR_DEST_LO = 3;
    localparam int IR_JMP_HI  = 2;
    localparam int IR_JMP_LO  = 0;

    // Bit indices inside the 3-bit dest and jmp fields.
    localparam int DEST_A = 2;
    localparam int DEST_D = 1;
    localparam int DEST_M = 0;
    localparam int JMP_LT = 2;
    localparam int JMP_EQ = 1;
    localparam int JMP_GT = 0;

    function automatic logic is_c_instr(input logic [15:0] ir);
        return ir[IR_TYPE];
    endfunction

endpackage

// File: rtl/hack_jump_unit.sv
// Combinational jump condition: compares the ALU sign/zero flags against the
// lt/eq/gt mask of a C-instruction.
module hack_jump_unit
    import hack_pkg::*;
(
    input  logic [2:0] jmp,
    input  logic       zr,
    input  logic       ng,
    output logic       jump
);

    assign jump = (jmp[JMP_LT] & ng) |
                  (jmp[JMP_EQ] & zr) |
                  (jmp[JMP_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control unit: fetch/decode, ALU operand steering, A/D/PC
// ownership and data-memory handshakes. Define HACK_CPU_TRAP_EN for the trap port.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_rd,
    output logic            dmem_we,
    output logic [14:0]     dmem_addr,
    output logic [15:0]     dmem_wdata,
    input  logic            dmem_ack,
    input  logic [15:0]     dmem_rdata,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [PC_W-1:0] pc_o
`ifdef HACK_CPU_TRAP_EN
    ,
    output logic            trap
`endif
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic [15:0]     areg_q, areg_d;
    logic [15:0]     dreg_q, dreg_d;
    logic [15:0]     mreg_q, mreg_d;
    logic [15:0]     ir_q, ir_d;
    logic [14:0]     waddr_q, waddr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [2:0]      dest;
    logic            jump;
    logic            illegal_c;

    assign dest   = ir_q[IR_DEST_HI:IR_DEST_LO];
    assign pc_inc = pc_q + PC_W'(1);

`ifdef HACK_CPU_TRAP_EN
    assign illegal_c = ir_q[14:13] != 2'b11;
    assign trap      = (state_q == TRAP);
`else
    assign illegal_c = 1'b0;
`endif

    hack_jump_unit u_jump (
        .jmp  (ir_q[IR_JMP_HI:IR_JMP_LO]),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .jump (jump)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        areg_d  = areg_q;
        dreg_d  = dreg_q;
        mreg_d  = mreg_q;
        ir_d    = ir_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!is_c_instr(ir_q)) begin
                    areg_d  = {1'b0, ir_q[14:0]};
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end else if (illegal_c) begin
                    state_d = TRAP;
                end else if (ir_q[IR_A]) begin
                    state_d = READ;
                end else begin
                    state_d = EXEC;
                end
            end
            READ: begin
                if (dmem_ack) begin
                    mreg_d  = dmem_rdata;
                    state_d = EXEC;
                end
            end
            // Write address and jump target both come from A before this instruction.
            EXEC: begin
                if (dest[DEST_D]) dreg_d = alu_out;
                if (dest[DEST_A]) areg_d = alu_out;
                waddr_d = areg_q[14:0];
                wdata_d = alu_out;
                pc_d    = jump ? areg_q[PC_W-1:0] : pc_inc;
                state_d = dest[DEST_M] ? WRITE : FETCH;
            end
            WRITE: begin
                if (dmem_ack) state_d = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            areg_q  <= '0;
            dreg_q  <= '0;
            mreg_q  <= '0;
            ir_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            areg_q  <= areg_d;
            dreg_q  <= dreg_d;
            mreg_q  <= mreg_d;
            ir_q    <= ir_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Requests come straight from the state so that reset drops them immediately.
    assign imem_req   = (state_q == FETCH) & ~reset;
    assign dmem_rd    = (state_q == READ)  & ~reset;
    assign dmem_we    = (state_q == WRITE) & ~reset;
    assign imem_addr  = pc_q;
    assign pc_o       = pc_q;
    assign dmem_addr  = (state_q == WRITE) ? waddr_q : areg_q[14:0];
    assign dmem_wdata = wdata_q;

    assign alu_x  = dreg_q;
    assign alu_y  = ir_q[IR_A] ? mreg_q : areg_q;
    assign alu_zx = ir_q[IR_COMP_HI];
    assign alu_nx = ir_q[IR_COMP_HI-1];
    assign alu_zy = ir_q[IR_COMP_HI-2];
    assign alu_ny = ir_q[IR_COMP_HI-3];
    assign alu_f  = ir_q[IR_COMP_LO+1];
    assign alu_no = ir_q[IR_COMP_LO];

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: instruction-level Hack model, random
// memory latencies and spurious acks, directed sequences, mid-handshake reset.
module tb_hack_cpu_ctrl;

    typedef struct {
        logic [15:0] instr;
        int          fWait;
        int          rWait;
        int          wWait;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dmem_rd;
    logic        dmem_we;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;
    logic [14:0] pc_o;
    logic [5:0]  aluCtrl;
`ifdef HACK_CPU_TRAP_EN
    logic        trap;
`endif

    int nCompared = 0;
    int nMismatched = 0;

    // Instruction-level model of the architectural state
    logic [15:0] mA, mD, mM, lastIr;
    logic [14:0] mPC;
    bit   [15:0] envMem [0:32767];
    bit   [15:0] modelMem [0:32767];

    entry_t progQ[$];
    entry_t curE;
    bit     fetchStarted, inFlight;
    int     fetchCnt, rdCnt, weCnt, rdSeen, weSeen, sinceAck, stall;
    int     expGap, expRdCycles, expWeCycles;
    logic [14:0] expRdAddr, expWAddr;
    logic [15:0] expWData;

    logic [14:0] fetchLog[$];
    logic [15:0] fetchAluX[$];
    logic [14:0] wrAddrLog[$];
    logic [15:0] wrDataLog[$];
    int          rdLog[$];
    int          weLog[$];

    hack_cpu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_rd    (dmem_rd),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_zx     (alu_zx),
        .alu_nx     (alu_nx),
        .alu_zy     (alu_zy),
        .alu_ny     (alu_ny),
        .alu_f      (alu_f),
        .alu_no     (alu_no),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .pc_o       (pc_o)
`ifdef HACK_CPU_TRAP_EN
        ,
        .trap       (trap)
`endif
    );

    always #5 clk = ~clk;

    // Standard Hack ALU as the environment on the other side of the interface
    function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? xx + yy : xx & yy;
        if (c[0]) r = ~r;
        return r;
    endfunction

    assign aluCtrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

    always_comb begin
        alu_out = hackAlu(alu_x, alu_y, aluCtrl);
        alu_zr  = (alu_out == 16'h0);
        alu_ng  = alu_out[15];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic entry_t randomEntry();
        entry_t e;
        if ($urandom_range(1) == 0) begin
            if ($urandom_range(15) == 0) e.instr = 16'h7FF0 | 16'($urandom_range(15));
            else                         e.instr = 16'($urandom_range(15));
        end else begin
            e.instr = {3'b111, 1'($urandom_range(1)), 6'($urandom_range(63)),
                       3'($urandom_range(7)), 3'($urandom_range(7))};
        end
        e.fWait = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
        e.rWait = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
        e.wWait = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
        return e;
    endfunction

    task automatic resetModel();
        mA = 16'h0; mD = 16'h0; mM = 16'h0; lastIr = 16'h0; mPC = 15'h0;
        fetchStarted = 0; inFlight = 0; stall = 0;
    endtask

    // Execute one instruction at ISA level and record what the bus must show
    task automatic executeModel(input entry_t e);
        logic [15:0] oldA, y, res;
        bit lt, eq, gt, take;
        oldA = mA;
        lastIr = e.instr;
        rdCnt = 0; weCnt = 0; rdSeen = 0; weSeen = 0; sinceAck = 0;
        inFlight = 1;
        expRdCycles = 0; expWeCycles = 0;
        if (!e.instr[15]) begin
            mA = {1'b0, e.instr[14:0]};
            mPC = mPC + 15'd1;
            expGap = 2;
        end else begin
            if (e.instr[12]) begin
                mM = modelMem[oldA[14:0]];
                expRdAddr = oldA[14:0];
                expRdCycles = e.rWait + 1;
            end
            y = e.instr[12] ? mM : oldA;
            res = hackAlu(mD, y, e.instr[11:6]);
            lt = res[15];
            eq = (res == 16'h0);
            gt = !lt && !eq;
            take = (e.instr[2] && lt) || (e.instr[1] && eq) || (e.instr[0] && gt);
            if (e.instr[3]) begin
                modelMem[oldA[14:0]] = res;
                expWAddr = oldA[14:0];
                expWData = res;
                expWeCycles = e.wWait + 1;
            end
            if (e.instr[5]) mA = res;
            if (e.instr[4]) mD = res;
            mPC = take ? oldA[14:0] : mPC + 15'd1;
            expGap = 3 + expRdCycles + expWeCycles;
        end
    endtask

    // One clock of memory service plus comparison of all visible outputs
    task automatic applyStimulus();
        int nReq;
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        nReq = int'(imem_req) + int'(dmem_rd) + int'(dmem_we);
        checkOutput("oneReq", 32'(nReq > 1), 32'd0);
        if (inFlight) sinceAck++;
        if (imem_req) stall = 0;
        else          stall++;
        if (stall == 60) checkOutput("fetchStall", stall, 0);

        if (imem_req) begin
            if (inFlight) begin
                checkOutput("latency", sinceAck, expGap);
                checkOutput("readCycles", rdSeen, expRdCycles);
                checkOutput("writeCycles", weSeen, expWeCycles);
                rdLog.push_back(rdSeen);
                weLog.push_back(weSeen);
                inFlight = 0;
            end
            checkOutput("imem_addr", imem_addr, mPC);
            checkOutput("pc_o", pc_o, mPC);
            checkOutput("alu_x", alu_x, mD);
            checkOutput("alu_y", alu_y, lastIr[12] ? mM : mA);
            checkOutput("aluCtrl", aluCtrl, lastIr[11:6]);
            if (!fetchStarted) begin
                if (progQ.size() > 0) curE = progQ.pop_front();
                else                  curE = randomEntry();
                fetchStarted = 1;
                fetchCnt = 0;
                fetchLog.push_back(imem_addr);
                fetchAluX.push_back(alu_x);
            end
            if (fetchCnt == curE.fWait) begin
                imem_ack = 1'b1;
                imem_rdata = curE.instr;
                fetchStarted = 0;
                executeModel(curE);
            end else begin
                fetchCnt++;
                imem_rdata = 16'($urandom);
            end
        end else if ($urandom_range(7) == 0) begin
            imem_ack = 1'b1;
            imem_rdata = 16'($urandom);
        end

        if (dmem_rd) begin
            checkOutput("rdAddr", dmem_addr, expRdAddr);
            checkOutput("rdAluCtrl", aluCtrl, lastIr[11:6]);
            rdSeen++;
            if (rdCnt == curRWait()) begin
                dmem_ack = 1'b1;
                dmem_rdata = envMem[dmem_addr];
            end
            rdCnt++;
        end else if (dmem_we) begin
            checkOutput("wrAddr", dmem_addr, expWAddr);
            checkOutput("wrData", dmem_wdata, expWData);
            weSeen++;
            if (weCnt == curWWait()) begin
                dmem_ack = 1'b1;
                envMem[dmem_addr] = dmem_wdata;
                wrAddrLog.push_back(dmem_addr);
                wrDataLog.push_back(dmem_wdata);
            end
            weCnt++;
        end else if ($urandom_range(7) == 0) begin
            dmem_ack = 1'b1;
            dmem_rdata = 16'($urandom);
        end
    endtask

    int rWaitNow, wWaitNow;
    function automatic int curRWait();
        return rWaitNow;
    endfunction
    function automatic int curWWait();
        return wWaitNow;
    endfunction

    // Waits belong to the instruction most recently handed to the DUT
    always @(posedge clk) begin
        if (imem_ack && imem_req) begin
            rWaitNow <= curE.rWait;
            wWaitNow <= curE.wWait;
        end
    end

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        resetModel();
    endtask

    initial begin
        int rdHigh;
        bit [15:0] v;
        reset = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        imem_rdata = 16'h0;
        dmem_rdata = 16'h0;
        for (int i = 0; i < 128; i++) begin
            v = 16'($urandom);
            envMem[i] = v;
            modelMem[i] = v;
        end
        resetModel();

        repeat (2) @(negedge clk);
        checkOutput("rstImemReq", imem_req, 0);
        checkOutput("rstDmemRd", dmem_rd, 0);
        checkOutput("rstDmemWe", dmem_we, 0);
        checkOutput("rstPc", pc_o, 0);
        checkOutput("rstAluX", alu_x, 0);
        checkOutput("rstAluY", alu_y, 0);
        reset = 1'b0;

        progQ.push_back('{16'h0005, 0, 0, 0});
        progQ.push_back('{16'hEC10, 0, 0, 0});
        progQ.push_back('{16'h0064, 0, 0, 0});
        progQ.push_back('{16'hE7C8, 0, 0, 0});
        progQ.push_back('{16'h0064, 1, 0, 0});
        progQ.push_back('{16'hFC90, 0, 2, 0});
        progQ.push_back('{16'h0014, 0, 0, 0});
        progQ.push_back('{16'hEA90, 0, 0, 0});
        progQ.push_back('{16'hE301, 0, 0, 0});
        progQ.push_back('{16'hEFD0, 0, 0, 0});
        progQ.push_back('{16'hE301, 0, 0, 0});
        progQ.push_back('{16'h7FFF, 0, 0, 0});
        progQ.push_back('{16'hEA87, 0, 0, 0});
        progQ.push_back('{16'h0003, 0, 0, 0});
        for (int i = 0; i < 300 && fetchLog.size() < 15; i++) applyStimulus();

        if (fetchLog.size() >= 15 && wrAddrLog.size() >= 1 && rdLog.size() >= 6) begin
            checkOutput("pcAfterAInstr", fetchLog[1], 15'd1);
            checkOutput("dEqualsA", fetchAluX[2], 16'd5);
            checkOutput("mWriteAddr", wrAddrLog[0], 15'd100);
            checkOutput("mWriteData", wrDataLog[0], 16'd6);
            checkOutput("oneCycleWrite", weLog[3], 1);
            checkOutput("heldRead", rdLog[5], 3);
            checkOutput("dMinusOne", fetchAluX[6], 16'd5);
            checkOutput("jgtNotTaken", fetchLog[9], 15'd9);
            checkOutput("jgtTaken", fetchLog[11], 15'd20);
            checkOutput("jmpToTop", fetchLog[13], 15'h7FFF);
            checkOutput("pcWrap", fetchLog[14], 15'd0);
        end else begin
            checkOutput("directedProgress", fetchLog.size(), 15);
        end

        for (int i = 0; i < 2500; i++) applyStimulus();

        // Reset in the middle of a read, with the ack arriving afterwards
        applyReset();
        progQ.push_back('{16'h0064, 0, 0, 0});
        progQ.push_back('{16'hFC10, 0, 50, 0});
        rdHigh = 0;
        for (int i = 0; i < 40 && rdHigh < 2; i++) begin
            applyStimulus();
            if (dmem_rd) rdHigh++;
        end
        checkOutput("reachedRead", rdHigh, 2);
        reset = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 16'hBEEF;
        #1;
        checkOutput("abortRd", dmem_rd, 0);
        checkOutput("abortImem", imem_req, 0);
        checkOutput("abortPc", pc_o, 0);
        checkOutput("abortD", alu_x, 0);
        @(negedge clk);
        reset = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("postRstFetch", imem_req, 1);
        checkOutput("postRstAddr", imem_addr, 15'd0);
        checkOutput("postRstRd", dmem_rd, 0);
        dmem_ack = 1'b0;
        progQ.push_back('{16'h1000, 0, 0, 0});
        for (int i = 0; i < 400; i++) applyStimulus();

`ifdef HACK_CPU_TRAP_EN
        applyReset();
        checkOutput("trapAtReset", trap, 0);
        progQ.push_back('{16'h8000, 0, 0, 0});
        for (int i = 0; i < 10 && (progQ.size() > 0 || fetchStarted); i++) applyStimulus();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("trapFlag", trap, 1);
            checkOutput("trapNoImem", imem_req, 0);
            checkOutput("trapNoRd", dmem_rd, 0);
            checkOutput("trapNoWe", dmem_we, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
